// File: rtl/ikaopll_bus_rx.sv
// ---------------------------------------------------------------------------
// ikaopll_bus_rx
//   Receive side of the YM2413-style CPU write bus for the IKAOPLL core.
//   The asynchronous bus pins are synchronized into the i_EMUCLK domain.
//   Address and data strobes are decoded, and each address/data pair is
//   queued as one register-write record. Records drain to the register
//   file over a valid/ready handshake.
//
//   Optional feature macro: IKAOPLL_BUSRX_TIMING_CHECK_EN
//     When defined, a busy counter models the chip's post-write wait times.
//     o_BUSY and o_TIMING_ERR are driven from it. When undefined, both
//     outputs are tied low.
//
// Ports
//   i_EMUCLK        system clock, rising edge
//   i_RST           asynchronous active-high reset
//   i_phiM_PCEN_n   phiM clock enable, active-low
//   i_CS_n, i_WR_n  asynchronous bus strobes
//   i_A0            asynchronous bus address select (0 = address, 1 = data)
//   i_D             asynchronous bus data
//   o_REG_ADDR      register address of the FIFO head
//   o_REG_DATA      register data of the FIFO head
//   o_REG_VALID     FIFO head valid
//   i_REG_READY     consumer accepts the head
//   o_FIFO_LEVEL    FIFO occupancy, 0 .. 2**FIFO_AW
//   o_OVF           sticky: data write dropped on a full FIFO
//   o_BUSY          post-write wait period active
//   o_TIMING_ERR    sticky: strobe committed while busy
// ---------------------------------------------------------------------------
module ikaopll_bus_rx #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FIFO_AW     = 2,
   parameter int unsigned ADDR_WAIT   = 12,
   parameter int unsigned DATA_WAIT   = 84
) (
   input  logic               i_EMUCLK,
   input  logic               i_RST,
   input  logic               i_phiM_PCEN_n,
   input  logic               i_CS_n,
   input  logic               i_WR_n,
   input  logic               i_A0,
   input  logic [7:0]         i_D,
   output logic [7:0]         o_REG_ADDR,
   output logic [7:0]         o_REG_DATA,
   output logic               o_REG_VALID,
   input  logic               i_REG_READY,
   output logic [FIFO_AW:0]   o_FIFO_LEVEL,
   output logic               o_OVF,
   output logic               o_BUSY,
   output logic               o_TIMING_ERR
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};

   // ------------------------------------------------------------------
   // Input synchronizers
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] cs_sr;
   logic [SYNC_STAGES-1:0] wr_sr;
   logic [SYNC_STAGES-1:0] a0_sr;
   logic [7:0]             d_sr [SYNC_STAGES];

   // The CS/WR chains reset to the active level. The ARM state therefore
   // waits until a genuinely idle bus has propagated through the chain,
   // and a strobe held across reset release is never decoded.
   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) begin
         cs_sr <= '0;
         wr_sr <= '0;
         a0_sr <= '0;
         for (int unsigned i = 0; i < SYNC_STAGES; i++) d_sr[i] <= '0;
      end else begin
         cs_sr   <= {cs_sr[SYNC_STAGES-2:0], i_CS_n};
         wr_sr   <= {wr_sr[SYNC_STAGES-2:0], i_WR_n};
         a0_sr   <= {a0_sr[SYNC_STAGES-2:0], i_A0};
         d_sr[0] <= i_D;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) d_sr[i] <= d_sr[i-1];
      end
   end

   logic       strobe;
   logic       a0_s;
   logic [7:0] d_s;

   assign strobe = ~(cs_sr[SYNC_STAGES-1] | wr_sr[SYNC_STAGES-1]);
   assign a0_s   = a0_sr[SYNC_STAGES-1];
   assign d_s    = d_sr[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Strobe decode FSM
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_ARM,
      ST_IDLE,
      ST_STROBE,
      ST_COMMIT
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   capture;
   logic   commit;

   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) state <= ST_ARM;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_ARM:    if (!strobe) state_nxt = ST_IDLE;
         ST_IDLE:   if (strobe)  state_nxt = ST_STROBE;
         ST_STROBE: if (!strobe) state_nxt = ST_COMMIT;
         ST_COMMIT: state_nxt = ST_IDLE;
         default:   state_nxt = ST_ARM;
      endcase
   end

   // Capture also runs on the IDLE cycle that first sees the strobe, so a
   // single synchronized active cycle still yields a valid A0/D sample.
   always_comb begin
      capture = 1'b0;
      commit  = 1'b0;
      case (state)
         ST_IDLE:   capture = strobe;
         ST_STROBE: capture = strobe;
         ST_COMMIT: commit  = 1'b1;
         default:   ;
      endcase
   end

   logic       cap_a0;
   logic [7:0] cap_d;
   logic [7:0] addr_lat;

   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) begin
         cap_a0 <= 1'b0;
         cap_d  <= '0;
      end else if (capture) begin
         cap_a0 <= a0_s;
         cap_d  <= d_s;
      end
   end

   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST)                 addr_lat <= '0;
      else if (commit && !cap_a0) addr_lat <= cap_d;
   end

   // ------------------------------------------------------------------
   // Record FIFO
   // ------------------------------------------------------------------
   logic [7:0]         mem_addr [DEPTH];
   logic [7:0]         mem_data [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0]   level;
   logic [7:0]         last_addr;
   logic [7:0]         last_data;
   logic               valid;
   logic               full;
   logic               push;
   logic               push_ok;
   logic               pop;
   logic               ovf;

   assign valid   = (level != '0);
   assign full    = (level == FULL_LVL);
   assign push    = commit & cap_a0;
   assign pop     = valid & i_REG_READY;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_ok = push & (~full | pop);

   always_ff @(posedge i_EMUCLK) begin
      if (push_ok) begin
         mem_addr[wr_ptr] <= addr_lat;
         mem_data[wr_ptr] <= cap_d;
      end
   end

   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         last_addr <= '0;
         last_data <= '0;
         ovf       <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr    <= rd_ptr + 1'b1;
            last_addr <= mem_addr[rd_ptr];
            last_data <= mem_data[rd_ptr];
         end
         case ({push_ok, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (push && !push_ok) ovf <= 1'b1;
      end
   end

   // When empty, the outputs keep showing the most recently popped record.
   assign o_REG_ADDR   = valid ? mem_addr[rd_ptr] : last_addr;
   assign o_REG_DATA   = valid ? mem_data[rd_ptr] : last_data;
   assign o_REG_VALID  = valid;
   assign o_FIFO_LEVEL = level;
   assign o_OVF        = ovf;

   // ------------------------------------------------------------------
   // Post-write wait checker
   // ------------------------------------------------------------------
`ifdef IKAOPLL_BUSRX_TIMING_CHECK_EN
   localparam int unsigned WAIT_MAX = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
   localparam int unsigned CW       = $clog2(WAIT_MAX + 1);

   logic [CW-1:0] busy_cnt;
   logic          terr;

   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) begin
         busy_cnt <= '0;
         terr     <= 1'b0;
      end else begin
         if (commit) begin
            busy_cnt <= cap_a0 ? CW'(DATA_WAIT) : CW'(ADDR_WAIT);
            if (busy_cnt != '0) terr <= 1'b1;
         end else if (!i_phiM_PCEN_n && busy_cnt != '0) begin
            busy_cnt <= busy_cnt - 1'b1;
         end
      end
   end

   assign o_BUSY       = (busy_cnt != '0);
   assign o_TIMING_ERR = terr;
`else
   logic unused_pcen;

   assign unused_pcen  = i_phiM_PCEN_n;
   assign o_BUSY       = 1'b0;
   assign o_TIMING_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_ikaopll_bus_rx.sv
module tb_ikaopll_bus_rx;

`ifdef IKAOPLL_BUSRX_TIMING_CHECK_EN
   localparam logic TCHK = 1'b1;
`else
   localparam logic TCHK = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       pcen_n;
   logic       cs_n;
   logic       wr_n;
   logic       a0;
   logic [7:0] d;
   logic [7:0] reg_addr;
   logic [7:0] reg_data;
   logic       reg_valid;
   logic       ready;
   logic [2:0] level;
   logic       ovf;
   logic       busy;
   logic       terr;

   int checks = 0;
   int fails  = 0;
   int pcnt   = 0;

   ikaopll_bus_rx #(
      .SYNC_STAGES(2),
      .FIFO_AW(2),
      .ADDR_WAIT(12),
      .DATA_WAIT(84)
   ) dut (
      .i_EMUCLK(clk),
      .i_RST(rst),
      .i_phiM_PCEN_n(pcen_n),
      .i_CS_n(cs_n),
      .i_WR_n(wr_n),
      .i_A0(a0),
      .i_D(d),
      .o_REG_ADDR(reg_addr),
      .o_REG_DATA(reg_data),
      .o_REG_VALID(reg_valid),
      .i_REG_READY(ready),
      .o_FIFO_LEVEL(level),
      .o_OVF(ovf),
      .o_BUSY(busy),
      .o_TIMING_ERR(terr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Divide-by-4 phiM enable, one clock wide, changed away from the rising edge.
   initial pcen_n = 1'b1;
   always @(negedge clk) begin
      pcnt   = pcnt + 1;
      pcen_n = ((pcnt % 4) != 0);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Strobe active for 4 clocks; returns at the negedge where CS/WR rise.
   task automatic bus_wr(input logic sel, input logic [7:0] val);
      @(negedge clk);
      a0   = sel;
      d    = val;
      cs_n = 1'b0;
      wr_n = 1'b0;
      tick(4);
      wr_n = 1'b1;
      cs_n = 1'b1;
   endtask

   initial begin
      rst   = 1'b1;
      cs_n  = 1'b1;
      wr_n  = 1'b1;
      a0    = 1'b0;
      d     = 8'h00;
      ready = 1'b0;

      // Reset state
      tick(3);
      chk("rst_valid", 32'(reg_valid), 32'h0);
      chk("rst_level", 32'(level), 32'h0);
      chk("rst_addr", 32'(reg_addr), 32'h00);
      chk("rst_data", 32'(reg_data), 32'h00);
      chk("rst_ovf", 32'(ovf), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_terr", 32'(terr), 32'h0);
      rst = 1'b0;
      tick(5);

      // Basic pair: address 0x00, data 0x7A, ready high
      ready = 1'b1;
      bus_wr(1'b0, 8'h00);
      tick(4);
      chk("addr_busy", 32'(busy), 32'(TCHK));
      tick(60);
      chk("addr_busy_done", 32'(busy), 32'h0);
      bus_wr(1'b1, 8'h7A);
      tick(3);
      chk("basic_latency_lo", 32'(reg_valid), 32'h0);
      tick(1);
      chk("basic_valid", 32'(reg_valid), 32'h1);
      chk("basic_addr", 32'(reg_addr), 32'h00);
      chk("basic_data", 32'(reg_data), 32'h7A);
      chk("basic_busy", 32'(busy), 32'(TCHK));
      tick(1);
      chk("basic_one_cycle", 32'(reg_valid), 32'h0);
      chk("basic_hold_data", 32'(reg_data), 32'h7A);
      chk("basic_level0", 32'(level), 32'h0);
      chk("basic_terr", 32'(terr), 32'h0);
      tick(350);
      chk("data_busy_done", 32'(busy), 32'h0);

      // Address reuse and backpressure
      ready = 1'b0;
      bus_wr(1'b0, 8'h10);
      tick(60);
      bus_wr(1'b1, 8'h01);
      tick(350);
      bus_wr(1'b1, 8'h02);
      tick(350);
      bus_wr(1'b1, 8'h03);
      tick(6);
      chk("bp_level", 32'(level), 32'h3);
      chk("bp_head_addr", 32'(reg_addr), 32'h10);
      chk("bp_head_data", 32'(reg_data), 32'h01);
      tick(344);
      chk("bp_hold_data", 32'(reg_data), 32'h01);
      ready = 1'b1;
      chk("bp_out0", 32'(reg_data), 32'h01);
      tick(1);
      chk("bp_out1", 32'(reg_data), 32'h02);
      chk("bp_out1_addr", 32'(reg_addr), 32'h10);
      tick(1);
      chk("bp_out2", 32'(reg_data), 32'h03);
      tick(1);
      chk("bp_empty", 32'(reg_valid), 32'h0);
      chk("bp_last_data", 32'(reg_data), 32'h03);
      ready = 1'b0;

      // Overflow: five data writes into a four-entry FIFO
      for (int i = 0; i < 5; i++) begin
         bus_wr(1'b1, 8'hA0 + 8'(i));
         tick(6);
         if (i == 3) begin
            chk("ovf_full_level", 32'(level), 32'h4);
            chk("ovf_not_yet", 32'(ovf), 32'h0);
         end
         tick(344);
      end
      chk("ovf_level_sat", 32'(level), 32'h4);
      chk("ovf_set", 32'(ovf), 32'h1);
      ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("ovf_drain", 32'(reg_data), 32'hA0 + 32'(i));
         tick(1);
      end
      chk("ovf_drained", 32'(reg_valid), 32'h0);
      chk("ovf_sticky", 32'(ovf), 32'h1);
      ready = 1'b0;
      tick(5);

      // Reset mid-strobe, strobe held across release
      a0   = 1'b1;
      d    = 8'h55;
      cs_n = 1'b0;
      wr_n = 1'b0;
      tick(4);
      rst = 1'b1;
      tick(1);
      chk("mid_rst_ovf", 32'(ovf), 32'h0);
      chk("mid_rst_level", 32'(level), 32'h0);
      chk("mid_rst_addr", 32'(reg_addr), 32'h00);
      chk("mid_rst_data", 32'(reg_data), 32'h00);
      rst = 1'b0;
      tick(8);
      wr_n = 1'b1;
      cs_n = 1'b1;
      tick(10);
      chk("mid_rst_no_rec", 32'(reg_valid), 32'h0);
      chk("mid_rst_level2", 32'(level), 32'h0);
      chk("mid_rst_terr", 32'(terr), 32'h0);
      bus_wr(1'b1, 8'h66);
      tick(4);
      chk("post_rst_valid", 32'(reg_valid), 32'h1);
      chk("post_rst_addr", 32'(reg_addr), 32'h00);
      chk("post_rst_data", 32'(reg_data), 32'h66);
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      tick(350);

      // Full FIFO: push coinciding with a pop is accepted
      for (int i = 0; i < 4; i++) begin
         bus_wr(1'b1, 8'hB0 + 8'(i));
         tick(350);
      end
      chk("pp_full", 32'(level), 32'h4);
      bus_wr(1'b1, 8'hB4);
      tick(3);
      ready = 1'b1;
      chk("pp_pre_level", 32'(level), 32'h4);
      tick(1);
      ready = 1'b0;
      chk("pp_level_same", 32'(level), 32'h4);
      chk("pp_no_ovf", 32'(ovf), 32'h0);
      chk("pp_head", 32'(reg_data), 32'hB1);
      ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         chk("pp_drain", 32'(reg_data), 32'hB0 + 32'(i));
         tick(1);
      end
      chk("pp_empty", 32'(reg_valid), 32'h0);
      tick(350);

      // Data write 20 phiM enables after the previous one
      bus_wr(1'b1, 8'hC1);
      tick(4);
      chk("tv_first_data", 32'(reg_data), 32'hC1);
      chk("tv_first_terr", 32'(terr), 32'h0);
      tick(72);
      bus_wr(1'b1, 8'hC2);
      tick(4);
      chk("tv_valid", 32'(reg_valid), 32'h1);
      chk("tv_data", 32'(reg_data), 32'hC2);
      chk("tv_terr", 32'(terr), 32'(TCHK));
      chk("tv_busy", 32'(busy), 32'(TCHK));
      tick(290);
      chk("tv_busy_reloaded", 32'(busy), 32'(TCHK));
      tick(60);
      chk("tv_busy_end", 32'(busy), 32'h0);
      chk("tv_terr_sticky", 32'(terr), 32'(TCHK));
      chk("tv_level", 32'(level), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
